// File: rtl/riscv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared pipeline types for the 5-stage RISC-V core.
//   XLEN_DEF    : default datapath width
//   REG_X0      : architectural zero register number
//   ex_ctrl_t   : packed EX-stage control bundle, MSB first:
//                 reg_write, mem_read, mem_write, mem_to_reg, alu_src,
//                 alu_op[3:0], branch, jump
//   EX_CTRL_NOP : all-zero control bundle, used for bubbles
// -----------------------------------------------------------------------------
package riscv_pipe_pkg;

    localparam int         XLEN_DEF = 32;
    localparam logic [4:0] REG_X0   = 5'd0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       branch;
        logic       jump;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector. Raises load_use_stall_o when
// the instruction in ID reads the destination of a load currently in EX.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rd_i : registered EX entry
//   id_valid_i, id_uses_rs1_i, id_rs1_i,
//   id_uses_rs2_i, id_rs2_i            : instruction currently in ID
//   flush_i                            : EX redirect, suppresses the stall
//   load_use_stall_o                   : hold PC and IF/ID, bubble ID/EX
// -----------------------------------------------------------------------------
module load_use_detect
    import riscv_pipe_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic       id_uses_rs1_i,
    input  logic [4:0] id_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic [4:0] id_rs2_i,
    input  logic       flush_i,
    output logic       load_use_stall_o
);

    logic w_ex_is_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // A load to x0 produces nothing worth waiting for.
    assign w_ex_is_load = ex_valid_i && ex_mem_read_i && (ex_rd_i != REG_X0);

    // Only operands the instruction actually reads can create a dependency.
    assign w_rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign w_rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

    // A flush kills the ID instruction anyway, so holding it would be wasted.
    assign load_use_stall_o = w_ex_is_load && id_valid_i &&
                              (w_rs1_hit || w_rs2_hit) && !flush_i;

endmodule

// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register with embedded load-use hazard detection.
// Optional build macro: ID_EX_BUBBLE_STATS_EN adds bubble/flush counters.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   stall_i              : global hold, freezes the register
//   flush_i              : branch/jump redirect from EX, loads a bubble
//   id_*                 : decoded instruction from ID (id_valid_i qualifies)
//   ex_*                 : registered copies presented to EX; ex_valid_o
//                          qualifies the entry, bubbles are all-zero
//   load_use_stall_o     : combinational; hold PC and IF/ID this cycle
//   lu_bubble_cnt_o      : (stats build) load-use bubbles inserted
//   flush_cnt_o          : (stats build) flush bubbles inserted
// Update priority per edge: rst > flush_i > stall_i > load-use > capture.
// -----------------------------------------------------------------------------
module id_ex_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    localparam int CTRL_W = $bits(ex_ctrl_t)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic [4:0]        id_rd_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [4:0]        ex_rs1_o,
    output logic [4:0]        ex_rs2_o,
    output logic [4:0]        ex_rd_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
`ifdef ID_EX_BUBBLE_STATS_EN
    output logic [31:0]       lu_bubble_cnt_o,
    output logic [31:0]       flush_cnt_o,
`endif
    output logic              load_use_stall_o
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    ex_ctrl_t        r_ctrl;

    logic            w_lu_stall;

    load_use_detect u_load_use_detect (
        .ex_valid_i       (r_valid),
        .ex_mem_read_i    (r_ctrl.mem_read),
        .ex_rd_i          (r_rd),
        .id_valid_i       (id_valid_i),
        .id_uses_rs1_i    (id_uses_rs1_i),
        .id_rs1_i         (id_rs1_i),
        .id_uses_rs2_i    (id_uses_rs2_i),
        .id_rs2_i         (id_rs2_i),
        .flush_i          (flush_i),
        .load_use_stall_o (w_lu_stall)
    );

    // Bubbles zero every field, including register numbers, so the
    // forwarding unit can never match against a dead entry.
    always_ff @(posedge clk) begin
        if (rst || flush_i || (!stall_i && (w_lu_stall || !id_valid_i))) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= REG_X0;
            r_rs2      <= REG_X0;
            r_rd       <= REG_X0;
            r_ctrl     <= EX_CTRL_NOP;
        end else if (!stall_i) begin
            r_valid    <= 1'b1;
            r_pc       <= id_pc_i;
            r_rs1_data <= id_rs1_data_i;
            r_rs2_data <= id_rs2_data_i;
            r_imm      <= id_imm_i;
            r_rs1      <= id_rs1_i;
            r_rs2      <= id_rs2_i;
            r_rd       <= id_rd_i;
            r_ctrl     <= id_ctrl_i;
        end
    end

`ifdef ID_EX_BUBBLE_STATS_EN
    logic [31:0] r_lu_bubble_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_lu_bubble;

    // A load-use bubble is only actually loaded when neither flush nor
    // stall pre-empts it; w_lu_stall already excludes flush.
    assign w_lu_bubble = w_lu_stall && !stall_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lu_bubble_cnt <= '0;
            r_flush_cnt     <= '0;
        end else begin
            if (w_lu_bubble && (r_lu_bubble_cnt != 32'hFFFF_FFFF))
                r_lu_bubble_cnt <= r_lu_bubble_cnt + 32'd1;
            if (flush_i && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign lu_bubble_cnt_o = r_lu_bubble_cnt;
    assign flush_cnt_o     = r_flush_cnt;
`endif

    assign ex_valid_o       = r_valid;
    assign ex_pc_o          = r_pc;
    assign ex_rs1_data_o    = r_rs1_data;
    assign ex_rs2_data_o    = r_rs2_data;
    assign ex_imm_o         = r_imm;
    assign ex_rs1_o         = r_rs1;
    assign ex_rs2_o         = r_rs2;
    assign ex_rd_o          = r_rd;
    assign ex_ctrl_o        = r_ctrl;
    assign load_use_stall_o = w_lu_stall;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;
    import riscv_pipe_pkg::*;

    localparam int XLEN   = 32;
    localparam int CTRL_W = $bits(ex_ctrl_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              stall_i, flush_i;
    logic              id_valid_i;
    logic [XLEN-1:0]   id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]        id_rs1_i, id_rs2_i, id_rd_i;
    logic              id_uses_rs1_i, id_uses_rs2_i;
    logic [CTRL_W-1:0] id_ctrl_i;
    logic              ex_valid_o;
    logic [XLEN-1:0]   ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0]        ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [CTRL_W-1:0] ex_ctrl_o;
    logic              load_use_stall_o;
`ifdef ID_EX_BUBBLE_STATS_EN
    logic [31:0]       lu_bubble_cnt_o, flush_cnt_o;
`endif

    id_ex_stage_reg #(.XLEN(XLEN)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .id_valid_i       (id_valid_i),
        .id_pc_i          (id_pc_i),
        .id_rs1_data_i    (id_rs1_data_i),
        .id_rs2_data_i    (id_rs2_data_i),
        .id_imm_i         (id_imm_i),
        .id_rs1_i         (id_rs1_i),
        .id_rs2_i         (id_rs2_i),
        .id_rd_i          (id_rd_i),
        .id_uses_rs1_i    (id_uses_rs1_i),
        .id_uses_rs2_i    (id_uses_rs2_i),
        .id_ctrl_i        (id_ctrl_i),
        .ex_valid_o       (ex_valid_o),
        .ex_pc_o          (ex_pc_o),
        .ex_rs1_data_o    (ex_rs1_data_o),
        .ex_rs2_data_o    (ex_rs2_data_o),
        .ex_imm_o         (ex_imm_o),
        .ex_rs1_o         (ex_rs1_o),
        .ex_rs2_o         (ex_rs2_o),
        .ex_rd_o          (ex_rd_o),
        .ex_ctrl_o        (ex_ctrl_o),
`ifdef ID_EX_BUBBLE_STATS_EN
        .lu_bubble_cnt_o  (lu_bubble_cnt_o),
        .flush_cnt_o      (flush_cnt_o),
`endif
        .load_use_stall_o (load_use_stall_o)
    );

    // ---------------- reference model ----------------
    // The EX slot is modelled as one instruction record; a bubble is simply
    // the empty record.
    typedef struct {
        bit              valid;
        logic [XLEN-1:0] pc, d1, d2, imm;
        logic [4:0]      rs1, rs2, rd;
        ex_ctrl_t        ctrl;
    } instr_t;

    instr_t      m_ex;
    int unsigned m_lu_cnt;
    int unsigned m_fl_cnt;

    int checks   = 0;
    int failures = 0;

    function automatic instr_t empty_slot();
        instr_t e;
        e.valid = 0; e.pc = '0; e.d1 = '0; e.d2 = '0; e.imm = '0;
        e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.ctrl = EX_CTRL_NOP;
        return e;
    endfunction

    function automatic instr_t id_instr();
        instr_t e;
        e.valid = 1; e.pc = id_pc_i; e.d1 = id_rs1_data_i; e.d2 = id_rs2_data_i;
        e.imm = id_imm_i; e.rs1 = id_rs1_i; e.rs2 = id_rs2_i; e.rd = id_rd_i;
        e.ctrl = ex_ctrl_t'(id_ctrl_i);
        return e;
    endfunction

    // Does the ID instruction need a value that the load in EX has not yet fetched?
    function automatic bit hazard();
        bit ex_load, dep;
        ex_load = m_ex.valid && m_ex.ctrl.mem_read && (m_ex.rd != 5'd0);
        dep = (id_uses_rs1_i && id_rs1_i == m_ex.rd) ||
              (id_uses_rs2_i && id_rs2_i == m_ex.rd);
        return ex_load && id_valid_i && dep && !flush_i;
    endfunction

    function automatic ex_ctrl_t mk_ctrl(bit load);
        ex_ctrl_t c;
        c = EX_CTRL_NOP;
        c.reg_write = 1'b1;
        c.mem_read  = load;
        c.mem_to_reg = load;
        c.alu_src   = load;
        c.alu_op    = load ? 4'd0 : 4'd1;
        return c;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ex();
        check("ex_valid", 64'(ex_valid_o), 64'(m_ex.valid));
        check("ex_pc", 64'(ex_pc_o), 64'(m_ex.pc));
        check("ex_rs1_data", 64'(ex_rs1_data_o), 64'(m_ex.d1));
        check("ex_rs2_data", 64'(ex_rs2_data_o), 64'(m_ex.d2));
        check("ex_imm", 64'(ex_imm_o), 64'(m_ex.imm));
        check("ex_rs1", 64'(ex_rs1_o), 64'(m_ex.rs1));
        check("ex_rs2", 64'(ex_rs2_o), 64'(m_ex.rs2));
        check("ex_rd", 64'(ex_rd_o), 64'(m_ex.rd));
        check("ex_ctrl", 64'(ex_ctrl_o), 64'(m_ex.ctrl));
`ifdef ID_EX_BUBBLE_STATS_EN
        check("lu_bubble_cnt", 64'(lu_bubble_cnt_o), 64'(m_lu_cnt));
        check("flush_cnt", 64'(flush_cnt_o), 64'(m_fl_cnt));
`endif
    endtask

    // One clock: check the combinational stall, advance model on the edge,
    // then check registered outputs 1 time unit after the edge.
    task automatic step();
        bit h;
        #1;
        h = hazard();
        check("load_use_stall", 64'(load_use_stall_o), 64'(h));
        @(posedge clk);
        if (rst) begin
            m_ex = empty_slot(); m_lu_cnt = 0; m_fl_cnt = 0;
        end else if (flush_i) begin
            m_ex = empty_slot(); m_fl_cnt++;
        end else if (stall_i) begin
            m_ex = m_ex;
        end else if (h) begin
            m_ex = empty_slot(); m_lu_cnt++;
        end else if (id_valid_i) begin
            m_ex = id_instr();
        end else begin
            m_ex = empty_slot();
        end
        #1;
        check_ex();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_id(input bit v, input logic [31:0] pc, input logic [4:0] rd,
                            input logic [4:0] rs1, input bit u1,
                            input logic [4:0] rs2, input bit u2, input bit load);
        id_valid_i    = v;
        id_pc_i       = pc;
        id_rd_i       = rd;
        id_rs1_i      = rs1;
        id_uses_rs1_i = u1;
        id_rs2_i      = rs2;
        id_uses_rs2_i = u2;
        id_rs1_data_i = 32'(rs1) * 32'd11 + 32'd5;
        id_rs2_data_i = 32'(rs2) * 32'd13 + 32'd9;
        id_imm_i      = pc ^ 32'h0000_0F0F;
        id_ctrl_i     = mk_ctrl(load);
    endtask

    task automatic drive_ctl(input bit r, input bit s, input bit f);
        rst = r; stall_i = s; flush_i = f;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_ex = empty_slot(); m_lu_cnt = 0; m_fl_cnt = 0;
        drive_ctl(1, 0, 0);
        drive_id(1, 32'h40, 5'd7, 5'd1, 1, 5'd2, 1, 0);

        // Reset with a live ID instruction pending.
        step(); step();
        check("reset_stall_zero", 64'(load_use_stall_o), 64'd0);

        // Capture add x3,x1,x2 at pc 0x100.
        drive_ctl(0, 0, 0);
        drive_id(1, 32'h100, 5'd3, 5'd1, 1, 5'd2, 1, 0);
        id_rs1_data_i = 32'd5; id_rs2_data_i = 32'd9;
        step();
        check("capture_pc", 64'(ex_pc_o), 64'h100);
        check("capture_rs1_data", 64'(ex_rs1_data_o), 64'd5);

        // Load-use: lw x5 then add x6,x5,x7.
        drive_id(1, 32'h104, 5'd5, 5'd1, 1, 5'd0, 0, 1);
        step();
        drive_id(1, 32'h108, 5'd6, 5'd5, 1, 5'd7, 1, 0);
        step();                                   // bubble loaded
        check("lu_bubble_rd", 64'(ex_rd_o), 64'd0);
        step();                                   // dependent captured
        check("lu_after_rd", 64'(ex_rd_o), 64'd6);

        // lw x0 followed by a reader of x0.
        drive_id(1, 32'h10C, 5'd0, 5'd1, 1, 5'd0, 0, 1);
        step();
        drive_id(1, 32'h110, 5'd4, 5'd0, 1, 5'd0, 1, 0);
        step();
        // lw x5 followed by non-dependent add x6,x8,x9.
        drive_id(1, 32'h114, 5'd5, 5'd1, 1, 5'd0, 0, 1);
        step();
        drive_id(1, 32'h118, 5'd6, 5'd8, 1, 5'd9, 1, 0);
        step();
        // Load followed by instruction naming x5 but not reading it.
        drive_id(1, 32'h11C, 5'd5, 5'd1, 1, 5'd0, 0, 1);
        step();
        drive_id(1, 32'h120, 5'd6, 5'd5, 0, 5'd5, 0, 0);
        step();

        // Flush with a load-use pending, then flush together with stall.
        drive_id(1, 32'h124, 5'd5, 5'd1, 1, 5'd0, 0, 1);
        step();
        drive_id(1, 32'h128, 5'd6, 5'd2, 0, 5'd5, 1, 0);
        drive_ctl(0, 0, 1);
        step();
        drive_id(1, 32'h12C, 5'd7, 5'd1, 1, 5'd2, 1, 0);
        drive_ctl(0, 0, 0);
        step();
        drive_ctl(0, 1, 1);
        step();

        // Stall hold over a load-use for 3 cycles, then release.
        drive_ctl(0, 0, 0);
        drive_id(1, 32'h130, 5'd5, 5'd1, 1, 5'd0, 0, 1);
        step();
        drive_id(1, 32'h134, 5'd6, 5'd5, 1, 5'd7, 1, 0);
        drive_ctl(0, 1, 0);
        step(); step(); step();
        check("hold_rd", 64'(ex_rd_o), 64'd5);
        drive_ctl(0, 0, 0);
        step();                                   // bubble
        step();                                   // add captured

        // Reset in the middle of a stall discards held contents.
        drive_id(1, 32'h138, 5'd5, 5'd1, 1, 5'd0, 0, 1);
        step();
        drive_id(1, 32'h13C, 5'd6, 5'd5, 1, 5'd7, 1, 0);
        drive_ctl(0, 1, 0);
        step();
        drive_ctl(1, 1, 0);
        step();
        drive_ctl(0, 0, 0);

        // Randomized traffic with small register range to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            drive_ctl($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
                      $urandom_range(0, 99) < 10);
            drive_id($urandom_range(0, 99) < 85, $urandom, 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 99) < 45);
            id_rs1_data_i = $urandom;
            id_rs2_data_i = $urandom;
            id_ctrl_i     = CTRL_W'($urandom);
            if ($urandom_range(0, 1) == 1) id_ctrl_i[9] = 1'b1;  // bias toward loads
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
